led_array_driver: RTL and testbench

LED_ARRAY_DRIVER -- requirements
Module: led_array_driver

---
 rtl/led_array_driver_if.sv | 23 ++
 rtl/led_array_driver.sv | 115 +++++++++++
 tb/tb_led_array_driver.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/led_array_driver_if.sv
// Frame-load handshake plus row/column drive for the LED matrix driver.
// Latency: none (wires only).
// Backpressure: cells_ready from the driver gates acceptance of cells_valid.
interface led_array_driver_if #(
    parameter int N = 8
);
    logic [N*N-1:0] cells;
    logic           cells_valid;
    logic           cells_ready;
    logic [N-1:0]   rows;
    logic [N-1:0]   cols;
    logic           frame_done;

    modport master (
        output cells, cells_valid,
        input  cells_ready, rows, cols, frame_done
    );

    modport slave (
        input  cells, cells_valid,
        output cells_ready, rows, cols, frame_done
    );
endinterface

// File: rtl/led_array_driver.sv
// Multiplexed NxN LED scan driver, double-buffered with tear-free swaps (LED_ARRAY_BLANKING_EN adds a blank clock per row).
// Latency: rows/cols registered one clock after the scan indices; a frame shows from the next frame boundary.
// Backpressure: cells_ready drops while a frame waits in pending and returns the cycle after the boundary swap.
module led_array_driver #(
    parameter int N    = 8,
    parameter int HOLD = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    led_array_driver_if.slave  bus
);
    localparam int RW = (N > 1) ? $clog2(N) : 1;
    localparam int HW = $clog2(HOLD);

`ifdef LED_ARRAY_BLANKING_EN
    typedef enum logic {SCAN, BLANK} state_t;
`else
    typedef enum logic {SCAN} state_t;
`endif

    state_t           r_state;
    state_t           w_state_nxt;
    logic [RW-1:0]    r_row;
    logic [RW-1:0]    w_row_nxt;
    logic [HW-1:0]    r_hold;
    logic [HW-1:0]    w_hold_nxt;
    logic [N*N-1:0]   r_active;
    logic [N*N-1:0]   r_pending;
    logic             r_pending_full;
    logic             w_pending_full_nxt;
    logic             r_ready;
    logic [N-1:0]     r_rows;
    logic [N-1:0]     r_cols;
    logic             r_wrap;
    logic             r_frame_done;
    logic             w_boundary;
    logic             w_capture;
    logic             w_hold_last;
    logic             w_row_last;

    assign w_hold_last = (r_hold == HW'(HOLD - 1));
    assign w_row_last  = (r_row == RW'(N - 1));
    assign w_capture   = bus.cells_valid && r_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_row_nxt   = r_row;
        w_hold_nxt  = r_hold;
        w_boundary  = 1'b0;
        case (r_state)
            SCAN: begin
                if (w_hold_last) begin
                    w_hold_nxt = '0;
`ifdef LED_ARRAY_BLANKING_EN
                    w_state_nxt = BLANK;
`else
                    w_row_nxt  = w_row_last ? '0 : r_row + 1'b1;
                    w_boundary = w_row_last;
`endif
                end else begin
                    w_hold_nxt = r_hold + 1'b1;
                end
            end
`ifdef LED_ARRAY_BLANKING_EN
            BLANK: begin
                w_state_nxt = SCAN;
                w_row_nxt   = w_row_last ? '0 : r_row + 1'b1;
                w_boundary  = w_row_last;
            end
`endif
            default: w_state_nxt = SCAN;
        endcase
    end

    // A capture can never coincide with a swap: ready implies pending is empty.
    always_comb begin
        w_pending_full_nxt = r_pending_full;
        if (w_boundary && r_pending_full) w_pending_full_nxt = 1'b0;
        if (w_capture)                    w_pending_full_nxt = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= SCAN;
            r_row          <= '0;
            r_hold         <= '0;
            r_active       <= '0;
            r_pending      <= '0;
            r_pending_full <= 1'b0;
            r_ready        <= 1'b0;
            r_rows         <= '0;
            r_cols         <= '1;
            r_wrap         <= 1'b0;
            r_frame_done   <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_row          <= w_row_nxt;
            r_hold         <= w_hold_nxt;
            if (w_boundary && r_pending_full) r_active <= r_pending;
            if (w_capture)                    r_pending <= bus.cells;
            r_pending_full <= w_pending_full_nxt;
            r_ready        <= !w_pending_full_nxt;
            r_rows         <= (r_state == SCAN) ? (N'(1) << r_row) : '0;
            r_cols         <= (r_state == SCAN) ? ~r_active[r_row*N +: N] : '1;
            // Two stages so the pulse lines up with row 0 reaching the outputs.
            r_wrap         <= w_boundary;
            r_frame_done   <= r_wrap;
        end
    end

    assign bus.cells_ready = r_ready;
    assign bus.rows        = r_rows;
    assign bus.cols        = r_cols;
    assign bus.frame_done  = r_frame_done;
endmodule

// File: tb/tb_led_array_driver.sv
// Randomized bench for led_array_driver; reference derives every output from the cycle count since reset.
module tb_led_array_driver;
    localparam int N    = 8;
    localparam int HOLD = 4;
`ifdef LED_ARRAY_BLANKING_EN
    localparam int SLOT = HOLD + 1;
`else
    localparam int SLOT = HOLD;
`endif
    localparam int P = N * SLOT;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    led_array_driver_if #(.N(N)) bus ();
    led_array_driver #(.N(N), .HOLD(HOLD)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    // Reference: t = rising edges since reset release; outputs after edge t+1 show scan step t.
    int             t      = 0;
    logic [N*N-1:0] m_act  = '0;
    logic [N*N-1:0] m_pend = '0;
    bit             m_pf   = 1'b0;
    logic [N-1:0]   e_rows = '0;
    logic [N-1:0]   e_cols = '1;
    logic           e_fd   = 1'b0;
    logic           e_rdy  = 1'b0;

    always @(posedge clk or negedge rst_n) begin : model
        int p, row, slot;
        bit cap;
        if (!rst_n) begin
            t = 0; m_act = '0; m_pend = '0; m_pf = 1'b0;
            e_rows = '0; e_cols = '1; e_fd = 1'b0; e_rdy = 1'b0;
        end else begin
            p    = t % P;
            row  = p / SLOT;
            slot = p % SLOT;
            if (slot < HOLD) begin
                e_rows = N'(1) << row;
                e_cols = ~m_act[row*N +: N];
            end else begin
                e_rows = '0;
                e_cols = '1;
            end
            e_fd = (p == 0) && (t > 0);
            cap  = bus.cells_valid && e_rdy;
            if (((t + 1) % P == 0) && m_pf) begin
                m_act = m_pend;
                m_pf  = 1'b0;
            end
            if (cap) begin
                m_pend = bus.cells;
                m_pf   = 1'b1;
            end
            e_rdy = !m_pf;
            t++;
        end
    end

    task automatic test_reset();
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (bus.rows !== 8'h00 || bus.cols !== 8'hFF || bus.frame_done !== 1'b0 || bus.cells_ready !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold got rows %h cols %h fd %b rdy %b, expected 00 ff 0 0",
                         bus.rows, bus.cols, bus.frame_done, bus.cells_ready);
            end
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.rows !== 8'h01 || bus.cols !== 8'hFF || bus.cells_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release got rows %h cols %h rdy %b, expected 01 ff 1",
                     bus.rows, bus.cols, bus.cells_ready);
        end
    endtask

    task automatic test_idle_scan();
        int last = -1;
        int pulses = 0;
        for (int i = 0; i < 3 * P; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.rows, bus.cols, bus.frame_done, bus.cells_ready} !== {e_rows, e_cols, e_fd, e_rdy}) begin
                errors++;
                $display("FAIL idle_scan t=%0d got rows %h cols %h fd %b rdy %b, expected %h %h %b %b",
                         t, bus.rows, bus.cols, bus.frame_done, bus.cells_ready, e_rows, e_cols, e_fd, e_rdy);
            end
            if (bus.frame_done === 1'b1) begin
                if (last >= 0) begin
                    checks++;
                    if (i - last != P) begin
                        errors++;
                        $display("FAIL frame_period got %0d, expected %0d", i - last, P);
                    end
                end
                last = i;
                pulses++;
            end
        end
        checks++;
        if (pulses != 2) begin
            errors++;
            $display("FAIL frame_done_count got %0d, expected 2", pulses);
        end
    endtask

    task automatic test_row0_frame();
        bit seen = 1'b0;
        @(negedge clk);
        bus.cells = 64'h0000_0000_0000_00FF;
        bus.cells_valid = 1'b1;
        for (int i = 0; i < 2 * P; i++) begin
            @(negedge clk);
            bus.cells_valid = 1'b0;
            checks++;
            if ({bus.rows, bus.cols, bus.frame_done, bus.cells_ready} !== {e_rows, e_cols, e_fd, e_rdy}) begin
                errors++;
                $display("FAIL row0_frame t=%0d got rows %h cols %h fd %b rdy %b, expected %h %h %b %b",
                         t, bus.rows, bus.cols, bus.frame_done, bus.cells_ready, e_rows, e_cols, e_fd, e_rdy);
            end
            if (bus.frame_done === 1'b1 && !seen) begin
                seen = 1'b1;
                checks++;
                if (bus.rows !== 8'h01 || bus.cols !== 8'h00) begin
                    errors++;
                    $display("FAIL row0_lit got rows %h cols %h, expected 01 00", bus.rows, bus.cols);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [N*N-1:0] a, b;
        a = {$urandom, $urandom};
        b = ~a;
        @(negedge clk);
        bus.cells = a;
        bus.cells_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.cells_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_ready got %b, expected 0", bus.cells_ready);
        end
        bus.cells = b;
        for (int i = 0; i < 2 * P; i++) begin
            @(negedge clk);
            bus.cells_valid = 1'b0;
            checks++;
            if ({bus.rows, bus.cols, bus.frame_done, bus.cells_ready} !== {e_rows, e_cols, e_fd, e_rdy}) begin
                errors++;
                $display("FAIL back_to_back t=%0d got rows %h cols %h fd %b rdy %b, expected %h %h %b %b",
                         t, bus.rows, bus.cols, bus.frame_done, bus.cells_ready, e_rows, e_cols, e_fd, e_rdy);
            end
        end
    endtask

    task automatic test_boundary_capture();
        logic [N*N-1:0] c;
        int fds = 0;
        c = {$urandom, $urandom};
        for (int i = 0; i < 3 * P; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.rows, bus.cols, bus.frame_done, bus.cells_ready} !== {e_rows, e_cols, e_fd, e_rdy}) begin
                errors++;
                $display("FAIL bnd_wait t=%0d got rows %h cols %h fd %b rdy %b, expected %h %h %b %b",
                         t, bus.rows, bus.cols, bus.frame_done, bus.cells_ready, e_rows, e_cols, e_fd, e_rdy);
            end
            if (((t + 1) % P == 0) && !m_pf) break;
        end
        checks++;
        if ((t + 1) % P != 0) begin
            errors++;
            $display("FAIL bnd_reach got t=%0d, expected a boundary", t);
        end
        bus.cells = c;
        bus.cells_valid = 1'b1;
        @(negedge clk);
        bus.cells_valid = 1'b0;
        checks++;
        if (bus.cells_ready !== 1'b0) begin
            errors++;
            $display("FAIL bnd_ready got %b, expected 0", bus.cells_ready);
        end
        for (int i = 0; i < 2 * P + 2; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.rows, bus.cols, bus.frame_done, bus.cells_ready} !== {e_rows, e_cols, e_fd, e_rdy}) begin
                errors++;
                $display("FAIL bnd_capture t=%0d got rows %h cols %h fd %b rdy %b, expected %h %h %b %b",
                         t, bus.rows, bus.cols, bus.frame_done, bus.cells_ready, e_rows, e_cols, e_fd, e_rdy);
            end
            if (bus.frame_done === 1'b1) begin
                fds++;
                if (fds == 2) begin
                    checks++;
                    if (bus.cols !== ~c[N-1:0]) begin
                        errors++;
                        $display("FAIL bnd_display got cols %h, expected %h", bus.cols, ~c[N-1:0]);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [N*N-1:0] d;
        d = {$urandom, $urandom};
        d[N-1:0] = 8'h5A;
        @(negedge clk);
        bus.cells = d;
        bus.cells_valid = 1'b1;
        for (int i = 0; i < 2 * P; i++) begin
            @(negedge clk);
            bus.cells_valid = 1'b0;
            checks++;
            if ({bus.rows, bus.cols, bus.frame_done, bus.cells_ready} !== {e_rows, e_cols, e_fd, e_rdy}) begin
                errors++;
                $display("FAIL mid_load t=%0d got rows %h cols %h fd %b rdy %b, expected %h %h %b %b",
                         t, bus.rows, bus.cols, bus.frame_done, bus.cells_ready, e_rows, e_cols, e_fd, e_rdy);
            end
            if (i > P && e_rows == 8'h20) break;
        end
        bus.cells = ~d;
        bus.cells_valid = 1'b1;
        @(negedge clk);
        bus.cells_valid = 1'b0;
        checks++;
        if (bus.rows !== 8'h20 || bus.cells_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_row5 got rows %h rdy %b, expected 20 0", bus.rows, bus.cells_ready);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.rows !== 8'h00 || bus.cols !== 8'hFF || bus.frame_done !== 1'b0 || bus.cells_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_async got rows %h cols %h fd %b rdy %b, expected 00 ff 0 0",
                     bus.rows, bus.cols, bus.frame_done, bus.cells_ready);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.rows !== 8'h01 || bus.cols !== 8'hFF) begin
            errors++;
            $display("FAIL mid_release got rows %h cols %h, expected 01 ff", bus.rows, bus.cols);
        end
        for (int i = 0; i < 2 * P; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.rows, bus.cols, bus.frame_done, bus.cells_ready} !== {e_rows, e_cols, e_fd, e_rdy}) begin
                errors++;
                $display("FAIL mid_after t=%0d got rows %h cols %h fd %b rdy %b, expected %h %h %b %b",
                         t, bus.rows, bus.cols, bus.frame_done, bus.cells_ready, e_rows, e_cols, e_fd, e_rdy);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 8 * P; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.rows, bus.cols, bus.frame_done, bus.cells_ready} !== {e_rows, e_cols, e_fd, e_rdy}) begin
                errors++;
                $display("FAIL random t=%0d got rows %h cols %h fd %b rdy %b, expected %h %h %b %b",
                         t, bus.rows, bus.cols, bus.frame_done, bus.cells_ready, e_rows, e_cols, e_fd, e_rdy);
            end
            bus.cells       = {$urandom, $urandom};
            bus.cells_valid = ($urandom_range(0, 5) == 0);
        end
        @(negedge clk);
        bus.cells_valid = 1'b0;
    endtask

    initial begin
        bus.cells       = '0;
        bus.cells_valid = 1'b0;
        test_reset();
        test_idle_scan();
        test_row0_frame();
        test_back_to_back();
        test_boundary_capture();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
